// File: rtl/wb_spi_flash_rd.sv
// Read-only Wishbone classic slave that maps an EPCS serial flash linearly.
// Each Wishbone read issues one 64-bit SPI READ (0x03) frame and returns
// the four data bytes little-endian. Writes are acked and ignored.
// A bit-bang bypass hands the flash pads straight to external pins.
// Ports:
//   wb_*        Wishbone classic slave (clk, async active-low reset).
//   bb_*        bit-bang bypass enable and pad values.
//   flash_*     SPI pads to the EPCS device (mode 0, MSB first).
module wb_spi_flash_rd #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_HIGH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        bb_en_i,
  input  logic        bb_sck_i,
  input  logic        bb_mosi_i,
  input  logic        bb_cs_n_i,
  output logic        flash_sck_o,
  output logic        flash_mosi_o,
  output logic        flash_cs_n_o,
  input  logic        flash_miso_i
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    BYPASS
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(CS_HIGH - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [5:0]  bit_q;
  logic [63:0] frame_q;
  logic [63:0] frame_ld;
  logic [31:0] rx_q;
  logic [31:0] dat_q;
  logic        sck_q;
  logic        mosi_q;
  logic        cs_n_q;
  logic        ack_q;
  logic        err_q;
  logic        live_q;

  logic req;
  logic rd_req;
  logic wr_req;
  logic phase_end;
  logic last_bit;
  logic unused_ok;

  assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_adr_i[1:0]};

  // A request is ignored while its own ack/err is still on the bus,
  // so a held strobe is never answered twice.
  assign req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign rd_req = req & ~wb_we_i & ~bb_en_i;
  assign wr_req = req & wb_we_i;

  assign phase_end = (cnt_q == DIV_M1);
  assign last_bit  = phase_end & sck_q & (bit_q == 6'd63);

  assign frame_ld = {8'h03, wb_adr_i[23:2], 2'b00, 32'h0};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = SHIFT;
        end else if (wr_req) begin
          state_d = IDLE;
        end else if (bb_en_i) begin
          state_d = BYPASS;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_M1) begin
          state_d = IDLE;
        end
      end
      BYPASS: begin
        if (!bb_en_i) begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      rx_q    <= '0;
      dat_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (rd_req) begin
            frame_q <= frame_ld;
            mosi_q  <= frame_ld[63];
            cs_n_q  <= 1'b0;
            sck_q   <= 1'b0;
            live_q  <= 1'b1;
          end else if (wr_req) begin
            ack_q <= 1'b1;
          end
        end
        SHIFT: begin
          // The frame always runs to completion; a dropped cycle only
          // suppresses the ack.
          if (!wb_cyc_i) begin
            live_q <= 1'b0;
          end
          if (!phase_end) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
              rx_q  <= {rx_q[30:0], flash_miso_i};
            end else if (last_bit) begin
              sck_q  <= 1'b0;
              mosi_q <= 1'b0;
              cs_n_q <= 1'b1;
              if (live_q && wb_cyc_i) begin
                ack_q <= 1'b1;
                dat_q <= {rx_q[7:0], rx_q[15:8],
                          rx_q[23:16], rx_q[31:24]};
              end
            end else begin
              sck_q   <= 1'b0;
              bit_q   <= bit_q + 6'd1;
              frame_q <= {frame_q[62:0], 1'b0};
              mosi_q  <= frame_q[62];
            end
          end
        end
        GAP: begin
          cnt_q <= cnt_q + 8'd1;
        end
        BYPASS: begin
          cnt_q <= '0;
          if (req) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    flash_sck_o  = sck_q;
    flash_mosi_o = mosi_q;
    flash_cs_n_o = cs_n_q;
    if (state_q == BYPASS) begin
      flash_sck_o  = bb_sck_i;
      flash_mosi_o = bb_mosi_i;
      flash_cs_n_o = bb_cs_n_i;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
